// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO bank for an rib slave slot.
// Up to 32 pins: per-pin direction, atomic OUT set/clear, a synchronised input
// and edge interrupts. int_sig_o is a level output.
// Optional feature: define GPIO_DEBOUNCE_EN to add a per-pin debounce filter
// between the synchroniser and the IN register and edge detector.
// Register map (word index addr_i[4:2]):
//   0 DIR, 1 OUT, 2 IN, 3 IRISE, 4 IFALL, 5 IPEND (W1C), 6 OUTSET, 7 OUTCLR
module gpio_bank #(
  parameter int NUM_IO      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic              int_sig_o
);

  localparam logic [2:0] A_DIR    = 3'd0;
  localparam logic [2:0] A_OUT    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_IRISE  = 3'd3;
  localparam logic [2:0] A_IFALL  = 3'd4;
  localparam logic [2:0] A_IPEND  = 3'd5;
  localparam logic [2:0] A_OUTSET = 3'd6;
  localparam logic [2:0] A_OUTCLR = 3'd7;

  // Elaboration-time sanity checks on the parameter ranges.
  if (NUM_IO < 1 || NUM_IO > 32) begin : g_bad_num_io
    $error("gpio_bank: NUM_IO must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("gpio_bank: SYNC_STAGES must be 2..3");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("gpio_bank: DB_CYCLES must be >= 2");
  end

  logic [2:0]        sel;
  logic [NUM_IO-1:0] wdata;

  logic [NUM_IO-1:0] dir_q,   dir_d;
  logic [NUM_IO-1:0] out_q,   out_d;
  logic [NUM_IO-1:0] irise_q, irise_d;
  logic [NUM_IO-1:0] ifall_q, ifall_d;
  logic [NUM_IO-1:0] ipend_q, ipend_d;
  logic [NUM_IO-1:0] prev_q;

  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] sync_out;
  logic [NUM_IO-1:0] filt;
  logic [NUM_IO-1:0] rise;
  logic [NUM_IO-1:0] fall;
  logic [NUM_IO-1:0] clr;

  // Only addr_i[4:2] and the low NUM_IO data bits matter; the rest is ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr_i[31:5], addr_i[1:0], data_i};

  assign sel   = addr_i[4:2];
  assign wdata = data_i[NUM_IO-1:0];

  // Input synchroniser chain for the asynchronous pads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= io_pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0]  cnt_q [NUM_IO];
  logic [NUM_IO-1:0] filt_q;

  // Per-pin debounce: the filtered value follows the synchronised input only
  // after it has differed for DB_CYCLES consecutive cycles; any bounce back
  // restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_IO; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (sync_out[i] != filt_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            filt_q[i] <= sync_out[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_out;
`endif

  assign rise = filt & ~prev_q;
  assign fall = ~filt & prev_q;

  // W1C mask for IPEND: only bits written as 1 during an IPEND write clear.
  always_comb begin
    clr = '0;
    if (we_i && sel == A_IPEND) begin
      clr = wdata;
    end
  end

  // Register next-state: direct writes, atomic set/clear on OUT, and edge
  // capture on IPEND where a new edge beats a simultaneous clear.
  always_comb begin
    dir_d   = dir_q;
    out_d   = out_q;
    irise_d = irise_q;
    ifall_d = ifall_q;
    if (we_i) begin
      case (sel)
        A_DIR:    dir_d   = wdata;
        A_OUT:    out_d   = wdata;
        A_IRISE:  irise_d = wdata;
        A_IFALL:  ifall_d = wdata;
        A_OUTSET: out_d   = out_q | wdata;
        A_OUTCLR: out_d   = out_q & ~wdata;
        default:  ;
      endcase
    end
    ipend_d = (ipend_q & ~clr) | (rise & irise_q) | (fall & ifall_q);
  end

  // Control/status registers and the previous filtered sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      irise_q <= '0;
      ifall_q <= '0;
      ipend_q <= '0;
      prev_q  <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      irise_q <= irise_d;
      ifall_q <= ifall_d;
      ipend_q <= ipend_d;
      prev_q  <= filt;
    end
  end

  // Read mux; bits at and above NUM_IO read as zero, write-only words read 0.
  always_comb begin
    data_o = '0;
    case (sel)
      A_DIR:   data_o[NUM_IO-1:0] = dir_q;
      A_OUT:   data_o[NUM_IO-1:0] = out_q;
      A_IN:    data_o[NUM_IO-1:0] = filt;
      A_IRISE: data_o[NUM_IO-1:0] = irise_q;
      A_IFALL: data_o[NUM_IO-1:0] = ifall_q;
      A_IPEND: data_o[NUM_IO-1:0] = ipend_q;
      default: ;
    endcase
  end

  assign io_out_o  = out_q;
  assign io_oe_o   = dir_q;
  // Masking an enable hides the pending bit from the interrupt but keeps it.
  assign int_sig_o = |(ipend_q & (irise_q | ifall_q));

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;
  localparam int NUM_IO      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + DB_CYCLES;
`else
  localparam int LAT = SYNC_STAGES;
`endif

  localparam int K_DATA = 0;
  localparam int K_INT  = 1;
  localparam int K_OUT  = 2;
  localparam int K_OE   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we_i = 1'b0;
  logic [31:0]       addr_i = '0;
  logic [31:0]       data_i = '0;
  logic [31:0]       data_o;
  logic [NUM_IO-1:0] io_pin_i = '0;
  logic [NUM_IO-1:0] io_out_o;
  logic [NUM_IO-1:0] io_oe_o;
  logic              int_sig_o;

  gpio_bank #(.NUM_IO(NUM_IO), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .io_pin_i(io_pin_i), .io_out_o(io_out_o),
    .io_oe_o(io_oe_o), .int_sig_o(int_sig_o)
  );

  initial forever #5 clk = ~clk;

  int          kind_q [$];
  logic [31:0] exp_q  [$];
  string       name_q [$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic        chk_req = 1'b0;

  int          m_kind;
  logic [31:0] m_exp;
  logic [31:0] m_act;
  string       m_name;

  // Monitor: when a sample is requested, pop every queued expectation and
  // compare it with the DUT output away from the active edge.
  always @(negedge clk) begin
    if (chk_req) begin
      while (exp_q.size() > 0) begin
        m_kind = kind_q.pop_front();
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        case (m_kind)
          K_DATA:  m_act = data_o;
          K_INT:   m_act = {31'd0, int_sig_o};
          K_OUT:   m_act = {{(32-NUM_IO){1'b0}}, io_out_o};
          default: m_act = {{(32-NUM_IO){1'b0}}, io_oe_o};
        endcase
        tests_run++;
        if (m_act !== m_exp) begin
          tests_failed++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic expect_v(input int kind, input logic [31:0] v, input string nm);
    kind_q.push_back(kind);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic sample();
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] w, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = {27'd0, w, 2'b00};
    data_i = d;
    @(posedge clk);
    #1;
    we_i   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] w, input logic [31:0] e, input string nm);
    addr_i = {27'd0, w, 2'b00};
    expect_v(K_DATA, e, nm);
    sample();
  endtask

  initial begin
    // Reset state
    step(3);
    rst = 1'b0;
    step(1);
    expect_v(K_OE, 0, "rst_oe");
    expect_v(K_OUT, 0, "rst_out_pin");
    expect_v(K_INT, 0, "rst_int");
    sample();
    rd(3'd0, 0, "rst_dir");
    rd(3'd1, 0, "rst_out");
    rd(3'd2, 0, "rst_in");
    rd(3'd5, 0, "rst_ipend");

    // Output path
    wr(3'd0, 32'h3);
    expect_v(K_OE, 3, "oe_dir3");
    sample();
    wr(3'd1, 32'h1);
    expect_v(K_OUT, 1, "out_wr1");
    sample();
    wr(3'd6, 32'h2);
    expect_v(K_OUT, 3, "out_set2");
    sample();
    wr(3'd7, 32'h1);
    expect_v(K_OUT, 2, "out_clr1");
    sample();
    rd(3'd1, 32'h2, "out_read");
    rd(3'd6, 0, "outset_read0");
    rd(3'd7, 0, "outclr_read0");
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h3, "dir_width");

    // Rising irq latency
    wr(3'd3, 32'h1);
    step(1);
    io_pin_i[0] = 1'b1;
    addr_i = {27'd0, 3'd2, 2'b00};
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk);
      #1;
      expect_v(K_DATA, (k >= LAT) ? 32'h1 : 32'h0, "in_latency");
      expect_v(K_INT, (k >= LAT + 1) ? 32'h1 : 32'h0, "int_latency");
      sample();
    end
    rd(3'd5, 32'h1, "ipend_rise");
    wr(3'd5, 32'h1);
    expect_v(K_INT, 0, "int_after_w1c");
    sample();
    rd(3'd5, 0, "ipend_w1c");

    // Edge vs W1C collision on pin1
    step(1);
    io_pin_i[1] = 1'b1;
    step(LAT + 3);
    wr(3'd4, 32'h2);
    rd(3'd5, 0, "rise_pin1_not_enabled");
    step(1);
    io_pin_i[1] = 1'b0;
    step(LAT);
    wr(3'd5, 32'h2);
    rd(3'd5, 32'h2, "collision_ipend");
    expect_v(K_INT, 1, "collision_int");
    sample();
    wr(3'd5, 32'h2);
    rd(3'd5, 0, "collision_clear");

    // Masked edges are discarded
    wr(3'd4, 32'h0);
    io_pin_i[1] = 1'b1;
    step(LAT + 3);
    io_pin_i[1] = 1'b0;
    step(LAT + 3);
    rd(3'd5, 0, "masked_ipend");
    expect_v(K_INT, 0, "masked_int");
    sample();

    // Clearing the enable masks int but keeps IPEND
    io_pin_i[0] = 1'b0;
    step(LAT + 3);
    io_pin_i[0] = 1'b1;
    step(LAT + 3);
    rd(3'd5, 32'h1, "ipend_before_mask");
    expect_v(K_INT, 1, "int_before_mask");
    sample();
    wr(3'd3, 32'h0);
    expect_v(K_INT, 0, "int_masked_now");
    sample();
    rd(3'd5, 32'h1, "ipend_kept");
    wr(3'd5, 32'h1);
    rd(3'd5, 0, "ipend_cleared");

    // Mid-run reset with pin0 held high
    wr(3'd1, 32'h3);
    wr(3'd3, 32'h1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    expect_v(K_OE, 0, "mid_rst_oe");
    expect_v(K_OUT, 0, "mid_rst_out");
    expect_v(K_INT, 0, "mid_rst_int");
    sample();
    rd(3'd0, 0, "mid_rst_dir");
    rd(3'd3, 0, "mid_rst_irise");
    step(LAT + 3);
    rd(3'd2, 32'h1, "held_high_in");
    rd(3'd5, 0, "held_high_no_ipend");

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short pulse rejected, long level accepted
    wr(3'd3, 32'h2);
    step(1);
    io_pin_i[1] = 1'b1;
    step(10);
    io_pin_i[1] = 1'b0;
    step(LAT + 5);
    rd(3'd2, 32'h1, "db_short_in");
    rd(3'd5, 0, "db_short_ipend");
    step(1);
    io_pin_i[1] = 1'b1;
    addr_i = {27'd0, 3'd2, 2'b00};
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk);
      #1;
      expect_v(K_DATA, (k >= LAT) ? 32'h3 : 32'h1, "db_long_in");
      sample();
    end
    rd(3'd5, 32'h2, "db_long_ipend");
    step(2);
    io_pin_i[1] = 1'b0;
    step(LAT + 3);
`endif

    step(2);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
